// File: rtl/multicycle_main_control_if.sv
// Control bus between the multi-cycle RV32I main controller and its datapath/memory.
// The controller takes the slave modport; the datapath side (or a bench) takes master.
interface multicycle_main_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] aluop;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    output opcode, zero, mem_ready,
    input  pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
           alu_src_a, alu_src_b, aluop, instr_done, illegal_op, state
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
           alu_src_a, alu_src_b, aluop, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences each instruction
// over 3-5 cycles (plus memory wait cycles) and drives mux selects and write enables.
module multicycle_main_control #(
  parameter bit ENABLE_JAL = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_main_control_if.slave      bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     r_state;
  state_t     w_next;
  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_aluop;
  logic       w_instr_done;
  logic       w_illegal_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_aluop      = 2'b00;
    w_instr_done = 1'b0;
    w_illegal_op = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC+4 computed on the ALU while the instruction is read
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
        w_next       = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BR:        w_next = S_BEQ;
          OP_JAL: begin
            if (ENABLE_JAL) begin
              w_next = S_JAL;
            end else begin
              w_illegal_op = 1'b1;
            end
          end
          default:      w_illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        w_next    = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        // strobe held until the memory accepts the write
        w_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = bus.mem_ready;
        w_next       = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_aluop     = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_aluop     = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JAL: begin
        // ALU forms oldPC+4 for the link register; PC takes target from ALUOut
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      S_BEQ: begin
        w_alu_src_a  = 2'b10;
        w_aluop      = 2'b01;
        w_pc_write   = bus.zero;
        w_instr_done = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase

    // reset is asynchronous, so enables must drop within the current cycle
    if (reset) begin
      w_pc_write   = 1'b0;
      w_ir_write   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_instr_done = 1'b0;
      w_illegal_op = 1'b0;
    end
  end

  assign bus.pc_write   = w_pc_write;
  assign bus.adr_src    = w_adr_src;
  assign bus.ir_write   = w_ir_write;
  assign bus.mem_write  = w_mem_write;
  assign bus.reg_write  = w_reg_write;
  assign bus.result_src = w_result_src;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.aluop      = w_aluop;
  assign bus.instr_done = w_instr_done;
  assign bus.illegal_op = w_illegal_op;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: the driver queues the expected
// control vector for each cycle; a negedge monitor pops and compares.
module tb_multicycle_main_control;

  logic clk;
  logic reset;
  multicycle_main_control_if bus ();

  multicycle_main_control #(.ENABLE_JAL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pc_write, adr_src, ir_write, mem_write, reg_write,
  //  result_src, alu_src_a, alu_src_b, aluop, instr_done, illegal_op}
  localparam logic [18:0] V_RST  = {4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b00,2'b10,2'b00, 1'b0,1'b0};
  localparam logic [18:0] V_F1   = {4'd0, 1'b1,1'b0,1'b1,1'b0,1'b0, 2'b10,2'b00,2'b10,2'b00, 1'b0,1'b0};
  localparam logic [18:0] V_F0   = {4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b00,2'b10,2'b00, 1'b0,1'b0};
  localparam logic [18:0] V_D    = {4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b01,2'b01,2'b00, 1'b0,1'b0};
  localparam logic [18:0] V_DILL = {4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b01,2'b01,2'b00, 1'b0,1'b1};
  localparam logic [18:0] V_MA   = {4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b01,2'b00, 1'b0,1'b0};
  localparam logic [18:0] V_MR   = {4'd3, 1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b0,1'b0};
  localparam logic [18:0] V_MWB  = {4'd4, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b01,2'b00,2'b00,2'b00, 1'b1,1'b0};
  localparam logic [18:0] V_MW0  = {4'd5, 1'b0,1'b1,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b0,1'b0};
  localparam logic [18:0] V_MW1  = {4'd5, 1'b0,1'b1,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b1,1'b0};
  localparam logic [18:0] V_ER   = {4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00,2'b10, 1'b0,1'b0};
  localparam logic [18:0] V_AWB  = {4'd7, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b00,2'b00, 1'b1,1'b0};
  localparam logic [18:0] V_EI   = {4'd8, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b01,2'b10, 1'b0,1'b0};
  localparam logic [18:0] V_JAL  = {4'd9, 1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b01,2'b10,2'b00, 1'b0,1'b0};
  localparam logic [18:0] V_BQ1  = {4'd10,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00,2'b01, 1'b1,1'b0};
  localparam logic [18:0] V_BQ0  = {4'd10,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00,2'b01, 1'b1,1'b0};

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  logic [18:0] q_exp [$];
  string       q_tag [$];
  int          checks = 0;
  int          errors = 0;

  logic [18:0] w_act;
  assign w_act = {bus.state, bus.pc_write, bus.adr_src, bus.ir_write, bus.mem_write,
                  bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                  bus.aluop, bus.instr_done, bus.illegal_op};

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      logic [18:0] exp_v;
      string       tag;
      exp_v = q_exp.pop_front();
      tag   = q_tag.pop_front();
      checks++;
      if (w_act !== exp_v) begin
        errors++;
        $display("FAIL %s: got %05h (state=%0d) want %05h (state=%0d)",
                 tag, w_act, w_act[18:15], exp_v, exp_v[18:15]);
      end
    end
  end

  task automatic step(input logic r, input logic [6:0] opc, input logic z,
                      input logic mr, input logic [18:0] exp_v, input string tag);
    reset         = r;
    bus.opcode    = opc;
    bus.zero      = z;
    bus.mem_ready = mr;
    q_exp.push_back(exp_v);
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.opcode    = 7'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    step(1, BAD, 0, 1, V_RST, "reset_hold0");
    step(1, BAD, 0, 1, V_RST, "reset_hold1");

    // lw, mem_ready high; opcode garbage in MEMREAD must be ignored
    step(0, LW,  0, 1, V_F1,  "lw_fetch");
    step(0, LW,  0, 1, V_D,   "lw_decode");
    step(0, LW,  0, 1, V_MA,  "lw_memadr");
    step(0, BAD, 0, 1, V_MR,  "lw_memread");
    step(0, BAD, 0, 1, V_MWB, "lw_memwb");

    // sw with two wait cycles in MEMWRITE
    step(0, SW,  0, 1, V_F1,  "sw_fetch");
    step(0, SW,  0, 1, V_D,   "sw_decode");
    step(0, SW,  0, 1, V_MA,  "sw_memadr");
    step(0, SW,  0, 0, V_MW0, "sw_memwrite_wait0");
    step(0, SW,  0, 0, V_MW0, "sw_memwrite_wait1");
    step(0, SW,  0, 1, V_MW1, "sw_memwrite_done");

    step(0, RT,  0, 1, V_F1,  "r_fetch");
    step(0, RT,  0, 1, V_D,   "r_decode");
    step(0, RT,  0, 1, V_ER,  "r_execr");
    step(0, RT,  0, 1, V_AWB, "r_aluwb");

    // fetch stall first, then I-type
    step(0, IT,  0, 0, V_F0,  "i_fetch_stall");
    step(0, IT,  0, 1, V_F1,  "i_fetch");
    step(0, IT,  0, 1, V_D,   "i_decode");
    step(0, IT,  0, 1, V_EI,  "i_execi");
    step(0, IT,  0, 1, V_AWB, "i_aluwb");

    step(0, JL,  0, 1, V_F1,  "jal_fetch");
    step(0, JL,  0, 1, V_D,   "jal_decode");
    step(0, JL,  0, 1, V_JAL, "jal_jal");
    step(0, JL,  0, 1, V_AWB, "jal_aluwb");

    step(0, BR,  1, 1, V_F1,  "beq_t_fetch");
    step(0, BR,  1, 1, V_D,   "beq_t_decode");
    step(0, BR,  1, 1, V_BQ1, "beq_taken");
    step(0, BR,  0, 1, V_F1,  "beq_n_fetch");
    step(0, BR,  0, 1, V_D,   "beq_n_decode");
    step(0, BR,  0, 1, V_BQ0, "beq_not_taken");

    step(0, BAD, 0, 1, V_F1,  "ill_fetch");
    step(0, BAD, 0, 1, V_DILL,"ill_decode");
    step(0, BAD, 0, 1, V_F1,  "ill_back_to_fetch");

    // reset asserted while a store is waiting in MEMWRITE
    step(0, SW,  0, 1, V_D,   "rst_sw_decode");
    step(0, SW,  0, 1, V_MA,  "rst_sw_memadr");
    step(0, SW,  0, 0, V_MW0, "rst_sw_memwrite");
    step(1, SW,  0, 1, V_RST, "rst_mid_memwrite");
    step(1, SW,  0, 1, V_RST, "rst_mid_hold");
    step(0, SW,  0, 1, V_F1,  "rst_release_fetch");
    step(0, SW,  0, 1, V_D,   "rst_release_decode");

    for (int i = 0; i < 5 && q_exp.size() > 0; i++) @(negedge clk);
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q_exp.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle RV32I datapath.
- Decodes the opcode and sequences each instruction over 3-5 cycles. Drives the datapath mux selects and write enables.
- Produces the 2-bit aluop consumed by the ALU control decoder:
  - 00 = add
  - 01 = subtract (branch compare)
  - 10 = decode from funct bits
- Handshakes with instruction/data memory through mem_ready.

Parameters:
- ENABLE_JAL, 1, when 0 the jal opcode is treated as illegal.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; state forced to FETCH
- opcode  in  7  instr[6:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has returned read data or accepted write this cycle
- pc_write  out  1  PC register load
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  instruction register and oldPC load
- mem_write  out  1  data memory write strobe
- reg_write  out  1  register file write
- result_src  out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4
- aluop  out  2  to ALU control decoder
- instr_done  out  1  one-cycle pulse in the final cycle of every completed instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- State register is 4 bits with asynchronous reset to FETCH.
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10.
- Codes 11-15 are unreachable; if entered, go to FETCH next cycle with all enables 0.
- Outputs are combinational from state, zero and mem_ready. Every signal not listed for a state is 0.
- While reset=1: pc_write, ir_write, mem_write, reg_write, instr_done and illegal_op are forced to 0. Selects take their FETCH values; state output = 0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, aluop=00, result_src=10.
  - ir_write=mem_ready, pc_write=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, aluop=00 (branch target captured in ALUOut). Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 (R-type) -> EXECR
  - 0010011 (I-type ALU) -> EXECI
  - 1100011 (branch) -> BEQ
  - 1101111 (jal) -> JAL if ENABLE_JAL=1
  - anything else -> FETCH with illegal_op=1
- MEMADR: alu_src_a=10, alu_src_b=01, aluop=00. Next is MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next is FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, held every cycle until mem_ready=1. On the mem_ready=1 cycle: instr_done=1, next is FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, aluop=10. Next is ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, aluop=10. Next is ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next is FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1. Next is ALUWB.
- BEQ: alu_src_a=10, alu_src_b=00, aluop=01, result_src=00, pc_write=zero, instr_done=1. Next is FETCH.
- Latency with mem_ready tied high, counted FETCH through final state inclusive:
  - lw 5 cycles
  - sw, R-type, I-type, jal 4 cycles
  - beq 3 cycles
  - Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- opcode is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- Reset asserted mid-instruction: the state goes to FETCH immediately (asynchronously) and write enables drop in the same cycle. No partial reg_write or mem_write pulse follows reset release.
- At most one of mem_write and reg_write is high in any cycle.

Test Plan:
- Reset with mem_ready=1, then release -> state=0; cycle 1 shows ir_write=1, pc_write=1, alu_src_b=10, aluop=00.
- lw (opcode 0000011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write and instr_done high only in state 4 with result_src=01.
- sw (0100011), mem_ready low for 2 cycles in MEMWRITE -> mem_write high 3 consecutive cycles; instr_done only on the third; total 6 cycles.
- R-type (0110011) -> EXECR shows aluop=10, alu_src_b=00; ALUWB shows reg_write=1. Repeat with I-type (0010011): EXECI shows alu_src_b=01.
- beq (1100011), first with zero=1 and then zero=0 -> BEQ shows aluop=01; pc_write=1 and 0 respectively; 3 cycles each.
- opcode 0000000 -> illegal_op pulses in DECODE, return to FETCH with no writes. Separately, reset asserted during MEMWRITE -> mem_write drops in the same cycle and state=0.
